// File: rtl/ecc_pkg.sv
// ecc_pkg: shared NIST P-256 curve constants, operand widths and the operand field index
package ecc_pkg;
   localparam int ECC_W      = 256;
   localparam int WORD_W     = 32;
   localparam int NUM_FIELDS = 5;
   localparam logic [ECC_W-1:0] CURVE_N  = 256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;
   localparam logic [ECC_W-1:0] CURVE_P  = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [ECC_W-1:0] CURVE_GX = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
   localparam logic [ECC_W-1:0] CURVE_GY = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
   localparam logic [ECC_W-1:0] CURVE_A  = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFC;
   localparam logic [ECC_W-1:0] CURVE_B  = 256'h5AC635D8AA3A93E7B3EBBD55769886BC651D06B0CC53B0F63BCE3C3E27D2604B;
   typedef enum logic [2:0] {R, S, HASH, PX, PY} field_e;
endpackage

// File: rtl/ecc_range_chk.sv
// ecc_range_chk: flags a signature whose r or s lies outside [1, n-1]; built only with ECC_SIG_RANGE_CHECK_EN
`ifdef ECC_SIG_RANGE_CHECK_EN
module ecc_range_chk
   import ecc_pkg::*;
(
   input  logic [ECC_W-1:0] r_i,
   input  logic [ECC_W-1:0] s_i,
   output logic             bad_o
);
   assign bad_o = ~|r_i || r_i >= CURVE_N || ~|s_i || s_i >= CURVE_N;
endmodule
`endif

// File: rtl/ecc_sig_loader.sv
// ecc_sig_loader: assembles a 40-word r/s/hash/Px/Py frame and issues it to the verifier;
// ECC_SIG_RANGE_CHECK_EN adds a CHECK state that rejects out-of-range r/s via the reject output
module ecc_sig_loader #(
   parameter int WORD_W          = ecc_pkg::WORD_W,
   parameter int WORDS_PER_FIELD = ecc_pkg::ECC_W / WORD_W,
   parameter int NUM_FIELDS      = ecc_pkg::NUM_FIELDS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WORD_W-1:0]         din,
   input  logic                      din_valid,
   input  logic                      din_last,
   output logic                      din_ready,
   input  logic                      ver_done,
   output logic [ecc_pkg::ECC_W-1:0] r,
   output logic [ecc_pkg::ECC_W-1:0] s,
   output logic [ecc_pkg::ECC_W-1:0] hash,
   output logic [ecc_pkg::ECC_W-1:0] Px,
   output logic [ecc_pkg::ECC_W-1:0] Py,
   output logic                      start,
   output logic                      frame_err,
   output logic                      busy
`ifdef ECC_SIG_RANGE_CHECK_EN
   ,
   output logic                      reject
`endif
);
   import ecc_pkg::*;

   localparam int LAST = NUM_FIELDS * WORDS_PER_FIELD - 1;

`ifdef ECC_SIG_RANGE_CHECK_EN
   typedef enum logic [1:0] {COLLECT, CHECK, ISSUE, WAIT} state_e;
`else
   typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_e;
`endif

   state_e                          state_q, state_d;
   logic [5:0]                      word_cnt_q, word_cnt_d;
   logic                            frame_err_q, frame_err_d;
   logic [NUM_FIELDS-1:0][ECC_W-1:0] fld_q, fld_d;
   logic [2:0]                      fld_sel;
   logic                            accept, at_last;

   assign accept  = din_valid && din_ready;
   assign at_last = word_cnt_q == 6'(LAST);
   assign fld_sel = 3'(word_cnt_q / 6'(WORDS_PER_FIELD));

   assign din_ready = state_q == COLLECT;
   assign start     = state_q == ISSUE;
   assign busy      = state_q == ISSUE || state_q == WAIT;
   assign frame_err = frame_err_q;
   assign r         = fld_q[R];
   assign s         = fld_q[S];
   assign hash      = fld_q[HASH];
   assign Px        = fld_q[PX];
   assign Py        = fld_q[PY];

`ifdef ECC_SIG_RANGE_CHECK_EN
   logic bad;
   ecc_range_chk u_range_chk (
      .r_i   (fld_q[R]),
      .s_i   (fld_q[S]),
      .bad_o (bad)
   );
   assign reject = state_q == CHECK && bad;
`endif

   // accepted words shift MSW-first into the field selected by the word counter
   always_comb begin
      fld_d = fld_q;
      if (accept) fld_d[fld_sel] = {fld_q[fld_sel][ECC_W-WORD_W-1:0], din};
   end

   // frame sequencing: collect, optional range check, one-cycle issue, hold until verifier completes
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      frame_err_d = 1'b0;
      case (state_q)
         COLLECT: if (accept) begin
            word_cnt_d  = (din_last || at_last) ? 6'd0 : word_cnt_q + 6'd1;
            frame_err_d = din_last != at_last;
`ifdef ECC_SIG_RANGE_CHECK_EN
            if (din_last && at_last) state_d = CHECK;
`else
            if (din_last && at_last) state_d = ISSUE;
`endif
         end
`ifdef ECC_SIG_RANGE_CHECK_EN
         CHECK:   state_d = bad ? COLLECT : ISSUE;
`endif
         ISSUE:   state_d = WAIT;
         WAIT: if (ver_done) begin
            state_d    = COLLECT;
            word_cnt_d = 6'd0;
         end
         default: state_d = COLLECT;
      endcase
   end

   // state, counter, error pulse and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         word_cnt_q  <= 6'd0;
         frame_err_q <= 1'b0;
         fld_q       <= '0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         frame_err_q <= frame_err_d;
         fld_q       <= fld_d;
      end
   end
endmodule

// File: tb/tb_ecc_sig_loader.sv
// tb_ecc_sig_loader: directed frames checked every cycle against a frame-level model plus literal spot checks
module tb_ecc_sig_loader;
   import ecc_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  din = '0;
   logic         din_valid = 1'b0, din_last = 1'b0, ver_done = 1'b0;
   logic         din_ready, start, frame_err, busy;
   logic [255:0] r, s, hash, Px, Py;
`ifdef ECC_SIG_RANGE_CHECK_EN
   logic         reject;
`endif

   int n_cmp = 0, n_bad = 0, n_start = 0, cyc = 0;

   // frame-level model state
   logic [255:0] m_ops [5];
   bit           m_locked;
   int           m_cnt, m_start_cycle, m_err_cycle, m_reject_cycle;
   logic [255:0] frame_ops [5];

   always #5 clk = ~clk;

   ecc_sig_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_last  (din_last),
      .din_ready (din_ready),
      .ver_done  (ver_done),
      .r         (r),
      .s         (s),
      .hash      (hash),
      .Px        (Px),
      .Py        (Py),
      .start     (start),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef ECC_SIG_RANGE_CHECK_EN
      ,
      .reject    (reject)
`endif
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 5; i++) m_ops[i] = '0;
      m_locked = 0;
      m_cnt = 0;
      m_start_cycle = -100;
      m_err_cycle = -100;
      m_reject_cycle = -100;
   endtask

   // a complete, correctly terminated frame either issues or (with range check) is rejected
   task automatic m_frame_done();
      m_locked = 1;
`ifdef ECC_SIG_RANGE_CHECK_EN
      if (m_ops[0] == 0 || m_ops[0] >= CURVE_N || m_ops[1] == 0 || m_ops[1] >= CURVE_N) begin
         m_reject_cycle = cyc;
         m_start_cycle = -100;
      end else m_start_cycle = cyc + 1;
`else
      m_start_cycle = cyc;
`endif
   endtask

   // one clock edge of the model; cycle label cyc is the interval following this edge
   task automatic m_edge();
      bit acc;
      cyc++;
      acc = !m_locked && din_valid;
      if (m_locked && m_reject_cycle == cyc - 1) m_locked = 0;
      if (m_locked && m_start_cycle >= 0 && cyc - 1 > m_start_cycle && ver_done) m_locked = 0;
      if (acc) begin
         m_ops[m_cnt / 8] = (m_ops[m_cnt / 8] << 32) | 256'(din);
         m_cnt++;
         if (din_last && m_cnt == 40) begin
            m_cnt = 0;
            m_frame_done();
         end else if (din_last || m_cnt == 40) begin
            m_cnt = 0;
            m_err_cycle = cyc;
         end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_edge();
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (start) n_start++;
      chk1("start", start, cyc == m_start_cycle);
      chk1("busy", busy, m_locked && m_start_cycle >= 0 && cyc >= m_start_cycle);
      chk1("din_ready", din_ready, !m_locked);
      chk1("frame_err", frame_err, cyc == m_err_cycle);
`ifdef ECC_SIG_RANGE_CHECK_EN
      chk1("reject", reject, cyc == m_reject_cycle);
`endif
      chk256("r", r, m_ops[0]);
      chk256("s", s, m_ops[1]);
      chk256("hash", hash, m_ops[2]);
      chk256("Px", Px, m_ops[3]);
      chk256("Py", Py, m_ops[4]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int nw, input int last_idx);
      logic [255:0] f;
      for (int i = 0; i < nw; i++) begin
         f = frame_ops[i / 8];
         din = f[255 - 32 * (i % 8) -: 32];
         din_valid = 1'b1;
         din_last = i == last_idx;
         tick();
      end
      din_valid = 1'b0;
      din_last = 1'b0;
   endtask

   task automatic wait_start();
`ifdef ECC_SIG_RANGE_CHECK_EN
      @(negedge clk);
      chk1("start_not_at_t1", start, 1'b0);
      tick();
`endif
      @(negedge clk);
      chk1("start_pulse", start, 1'b1);
   endtask

   task automatic finish_job(input int n);
      repeat (n) tick();
      ver_done = 1'b1;
      tick();
      ver_done = 1'b0;
      @(negedge clk);
      chk1("ready_after_done", din_ready, 1'b1);
      chk1("busy_after_done", busy, 1'b0);
      tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_ready", din_ready, 1'b1);
      chk1("rst_start", start, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk256("rst_r", r, '0);
      chk256("rst_Py", Py, '0);
      tick();
      rst_n = 1'b1;
      tick();

      // nominal frame, then backpressure with a changing word during WAIT
      frame_ops = '{256'd1, 256'd2, 256'd3, CURVE_GX, CURVE_GY};
      send(40, 39);
      wait_start();
      chk256("nom_r", r, 256'd1);
      chk256("nom_s", s, 256'd2);
      chk256("nom_hash", hash, 256'd3);
      chk256("nom_Px", Px, CURVE_GX);
      chk256("nom_Py", Py, CURVE_GY);
      chk1("nom_ready_low", din_ready, 1'b0);
      tick();
      for (int i = 0; i < 99; i++) begin
         din_valid = 1'b1;
         din = $urandom;
         din_last = 1'($urandom_range(0, 1));
         tick();
      end
      din_valid = 1'b0;
      din_last = 1'b0;
      chk256("bp_hold_s", s, 256'd2);
      chk256("bp_hold_Py", Py, CURVE_GY);
      finish_job(0);

      // early last on word 17, then a good frame
      frame_ops = '{{8{32'hA5A5_0001}}, {8{32'h1234_5678}}, 256'hDEAD_BEEF_CAFE_F00D_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001, 256'd7, 256'd8};
      send(18, 17);
      @(negedge clk);
      chk1("early_err", frame_err, 1'b1);
      chk1("early_no_start", start, 1'b0);
      chk256("early_r", r, {8{32'hA5A5_0001}});
      chk256("early_hash", hash, (256'd3 << 64) | 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_DEAD_BEEF_CAFE_F00D);
      tick();
      frame_ops = '{256'd11, 256'd22, 256'd33, CURVE_GY, CURVE_GX};
      send(40, 39);
      wait_start();
      chk256("good_r", r, 256'd11);
      chk256("good_Px", Px, CURVE_GY);
      finish_job(5);

      // missing last on word 39
      frame_ops = '{256'd101, 256'd102, 256'd103, 256'd104, 256'd105};
      send(40, -1);
      @(negedge clk);
      chk1("miss_err", frame_err, 1'b1);
      chk1("miss_no_start", start, 1'b0);
      chk256("miss_word_cnt", 256'(dut.word_cnt_q), '0);
      chk256("miss_Py", Py, 256'd105);
      tick();

      // reset mid-frame after word 20, then a full frame
      frame_ops = '{256'd201, 256'd202, 256'd203, 256'd204, 256'd205};
      send(21, -1);
      rst_n = 1'b0;
      @(negedge clk);
      chk1("mid_rst_ready", din_ready, 1'b1);
      chk1("mid_rst_err", frame_err, 1'b0);
      chk256("mid_rst_hash", hash, '0);
      tick();
      rst_n = 1'b1;
      tick();
      frame_ops = '{CURVE_GX, CURVE_GY, 256'd9, 256'd10, 256'd12};
      send(40, 39);
      wait_start();
      chk256("after_rst_r", r, CURVE_GX);
      chk256("after_rst_Py", Py, 256'd12);
      finish_job(2);

`ifdef ECC_SIG_RANGE_CHECK_EN
      // s == n is rejected, s == n-1 issues at T+2
      frame_ops = '{256'd1, CURVE_N, 256'd3, 256'd4, 256'd5};
      send(40, 39);
      @(negedge clk);
      chk1("rng_reject", reject, 1'b1);
      chk1("rng_no_start", start, 1'b0);
      tick();
      @(negedge clk);
      chk1("rng_ready_back", din_ready, 1'b1);
      tick();
      frame_ops = '{256'd1, CURVE_N - 256'd1, 256'd3, 256'd4, 256'd5};
      send(40, 39);
      wait_start();
      chk1("rng_no_reject", reject, 1'b0);
      finish_job(3);
      chk256("start_count", 256'(n_start), 256'd4);
`else
      chk256("start_count", 256'(n_start), 256'd3);
`endif
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
